// File: rtl/game_pkg.sv
// Shared types and constants for the dino game pace controller and its tick dividers.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam int SCORE_W = 14;
    localparam int LEVEL_W = 3;
    // Wide enough for the largest default divider period (3,000,000 cycles).
    localparam int DIV_W   = 22;

    localparam int DEF_SCORE_DIV     = 3000000;
    localparam int DEF_OBST_DIV_BASE = 270000;
    localparam int DEF_OBST_DIV_STEP = 20000;
    localparam int DEF_OBST_DIV_MIN  = 90000;
    localparam int DEF_LEVEL_PTS     = 100;
    localparam int DEF_MAX_LEVEL     = 7;
    localparam int DEF_SCORE_MAX     = 9999;

    // Obstacle period for a given level, clamped to the floor.
    function automatic logic [DIV_W-1:0] obst_period(input logic [LEVEL_W-1:0] lvl,
                                                     input int base,
                                                     input int step,
                                                     input int floor_p);
        int p;
        p = base - int'(lvl) * step;
        if (p < floor_p) p = floor_p;
        return DIV_W'(p);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running period divider with a registered one-cycle tick; the period is
// re-sampled only at wrap (or while cleared) so a running period is never cut short.
module tick_divider
    import game_pkg::*;
#(
    parameter logic [DIV_W-1:0] RESET_PERIOD = DIV_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick,
    output logic             wrap
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period_q;

    assign wrap = en && !clr && (cnt == period_q - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            tick     <= 1'b0;
            period_q <= RESET_PERIOD;
        end else if (clr) begin
            cnt      <= '0;
            tick     <= 1'b0;
            period_q <= period;
        end else if (wrap) begin
            cnt      <= '0;
            tick     <= 1'b1;
            period_q <= period;
        end else begin
            tick <= 1'b0;
            if (en) cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/game_pace_controller.sv
// Game state sequencer and tick scheduler: IDLE/PLAY/OVER FSM, score/level keeping,
// and level-dependent obstacle speed. Optional high-score register under GAME_HISCORE_EN.
module game_pace_controller
    import game_pkg::*;
#(
    parameter int SCORE_DIV     = DEF_SCORE_DIV,
    parameter int OBST_DIV_BASE = DEF_OBST_DIV_BASE,
    parameter int OBST_DIV_STEP = DEF_OBST_DIV_STEP,
    parameter int OBST_DIV_MIN  = DEF_OBST_DIV_MIN,
    parameter int LEVEL_PTS     = DEF_LEVEL_PTS,
    parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
    parameter int SCORE_MAX     = DEF_SCORE_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               collision,
    output logic [1:0]         state,
    output logic               gameon,
    output logic               score_tick,
    output logic               obstacle_tick,
    output logic [SCORE_W-1:0] score,
`ifdef GAME_HISCORE_EN
    output logic [SCORE_W-1:0] hiscore,
`endif
    output logic [LEVEL_W-1:0] level
);

    localparam int PTS_W = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;
    localparam logic [DIV_W-1:0]   SCORE_P  = DIV_W'(SCORE_DIV);
    localparam logic [DIV_W-1:0]   BASE_P   = DIV_W'(OBST_DIV_BASE);
    localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);
    localparam logic [LEVEL_W-1:0] LEVEL_SAT = LEVEL_W'(MAX_LEVEL);
    localparam logic [PTS_W-1:0]   PTS_LAST  = PTS_W'(LEVEL_PTS - 1);

    game_state_t state_q, state_d;
    logic [PTS_W-1:0] pts;
    logic [DIV_W-1:0] obst_p;
    logic playing, enter_play, div_clr;
    logic score_wrap, obst_wrap_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_PLAY;
            ST_PLAY: if (collision) state_d = ST_OVER;
            ST_OVER: if (start)     state_d = ST_PLAY;
            default:                state_d = ST_IDLE;
        endcase
    end

    assign state      = state_q;
    assign playing    = (state_q == ST_PLAY);
    assign gameon     = playing;
    assign enter_play = !playing && (state_d == ST_PLAY);
    // Collision clears the dividers in the same cycle, which also swallows a coinciding wrap.
    assign div_clr    = !playing || collision;
    assign obst_p     = playing ? obst_period(level, OBST_DIV_BASE, OBST_DIV_STEP, OBST_DIV_MIN)
                                : BASE_P;

    tick_divider #(.RESET_PERIOD(SCORE_P)) u_score_div (
        .clk    (clk),
        .rst    (rst),
        .en     (playing),
        .clr    (div_clr),
        .period (SCORE_P),
        .tick   (score_tick),
        .wrap   (score_wrap)
    );

    tick_divider #(.RESET_PERIOD(BASE_P)) u_obst_div (
        .clk    (clk),
        .rst    (rst),
        .en     (playing),
        .clr    (div_clr),
        .period (obst_p),
        .tick   (obstacle_tick),
        .wrap   (obst_wrap_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
            level <= '0;
            pts   <= '0;
        end else if (enter_play) begin
            score <= '0;
            level <= '0;
            pts   <= '0;
        end else if (score_wrap && (score != SCORE_SAT)) begin
            score <= score + SCORE_W'(1);
            if (pts == PTS_LAST) begin
                pts <= '0;
                if (level != LEVEL_SAT) level <= level + LEVEL_W'(1);
            end else begin
                pts <= pts + PTS_W'(1);
            end
        end
    end

`ifdef GAME_HISCORE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        hiscore <= '0;
        else if (playing && collision && score > hiscore) hiscore <= score;
    end
`endif

endmodule

// File: tb/tb_game_pace_controller.sv
// Directed bench for game_pace_controller with small divider parameters; tick timing
// and score values go through an expected queue, everything else is checked inline.
module tb_game_pace_controller;

    localparam int SD   = 4;
    localparam int OB   = 10;
    localparam int OS   = 2;
    localparam int OM   = 4;
    localparam int LP   = 3;
    localparam int ML   = 7;
    localparam int SMAX = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        collision;
    logic [1:0]  state;
    logic        gameon;
    logic        score_tick;
    logic        obstacle_tick;
    logic [13:0] score;
    logic [2:0]  level;
`ifdef GAME_HISCORE_EN
    logic [13:0] hiscore;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] val_q[$];
    logic [31:0] obs_q[$];

    game_pace_controller #(
        .SCORE_DIV     (SD),
        .OBST_DIV_BASE (OB),
        .OBST_DIV_STEP (OS),
        .OBST_DIV_MIN  (OM),
        .LEVEL_PTS     (LP),
        .MAX_LEVEL     (ML),
        .SCORE_MAX     (SMAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .collision     (collision),
        .state         (state),
        .gameon        (gameon),
        .score_tick    (score_tick),
        .obstacle_tick (obstacle_tick),
        .score         (score),
`ifdef GAME_HISCORE_EN
        .hiscore       (hiscore),
`endif
        .level         (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int any_tick;
        int t, p, nb, sc, lv;

        rst = 1'b1; start = 1'b0; collision = 1'b0;
        step(); step();
        check("rst_state", 32'(state), 0);
        check("rst_gameon", 32'(gameon), 0);
        check("rst_score", 32'(score), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ticks", 32'(score_tick | obstacle_tick), 0);
        rst = 1'b0;

        // Idle with random collision noise: must stay quiet.
        any_tick = 0;
        for (int i = 0; i < 50; i++) begin
            collision = 1'($urandom_range(0, 1));
            step();
            if (score_tick || obstacle_tick || state != 2'd0) any_tick = 1;
        end
        collision = 1'b0;
        check("idle_quiet", 32'(any_tick), 0);
        check("idle_score", 32'(score), 0);

        pulse_start();
        check("play_state", 32'(state), 1);
        check("play_gameon", 32'(gameon), 1);

        for (int n = 1; n <= 25; n++) begin
            exp_q.push_back(32'(SD * n));
            val_q.push_back(32'((n > SMAX) ? SMAX : n));
        end
        // Obstacle schedule: next period uses the level held just before each wrap edge.
        t = 0; p = OB;
        while (t + p <= 100) begin
            t = t + p;
            obs_q.push_back(32'(t));
            nb = (t - 1) / SD;
            sc = (nb > SMAX) ? SMAX : nb;
            lv = sc / LP;
            if (lv > ML) lv = ML;
            p = OB - OS * lv;
            if (p < OM) p = OM;
        end

        for (int k = 1; k <= 100; k++) begin
            step();
            if (score_tick) begin
                if (exp_q.size() == 0) check("score_tick_extra", 1, 0);
                else begin
                    check("score_tick_cycle", 32'(k), exp_q.pop_front());
                    check("score_at_tick", 32'(score), val_q.pop_front());
                end
            end
            if (obstacle_tick) begin
                if (obs_q.size() == 0) check("obst_tick_extra", 1, 0);
                else check("obst_tick_cycle", 32'(k), obs_q.pop_front());
            end
            if (k == 12) check("level1_at_score3", 32'(level), 1);
            if (k == 24) check("level2_at_score6", 32'(level), 2);
        end
        check("score_q_drained", 32'(exp_q.size()), 0);
        check("obst_q_drained", 32'(obs_q.size()), 0);
        check("sat_score", 32'(score), 20);
        check("sat_level", 32'(level), 6);

        collision = 1'b1;
        step();
        check("over_state", 32'(state), 2);
        check("over_score_hold", 32'(score), 20);
        any_tick = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (score_tick || obstacle_tick || state != 2'd2) any_tick = 1;
        end
        collision = 1'b0;
        check("collision_in_over", 32'(any_tick), 0);

        pulse_start();
        check("restart_state", 32'(state), 1);
        check("restart_score", 32'(score), 0);
        check("restart_level", 32'(level), 0);
        for (int k = 1; k <= 23; k++) begin
            step();
            if (k == 20) check("score5", 32'(score), 5);
        end
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("coll_wrap_state", 32'(state), 2);
        check("coll_wrap_no_tick", 32'(score_tick), 0);
        check("coll_wrap_score", 32'(score), 5);

        pulse_start();
        check("restart2_score", 32'(score), 0);
        any_tick = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (score_tick) any_tick = 1;
        end
        step();
        check("restart2_early_tick", 32'(any_tick), 0);
        check("restart2_first_tick", 32'(score_tick), 1);
        check("restart2_score1", 32'(score), 1);

        start = 1'b1; collision = 1'b1;
        step();
        start = 1'b0; collision = 1'b0;
        check("start_coll_state", 32'(state), 2);
        step();
        check("start_coll_hold", 32'(state), 2);

        pulse_start();
        for (int k = 1; k <= 8; k++) step();
        check("pre_rst_tick", 32'(score_tick), 1);
        check("pre_rst_score", 32'(score), 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 0);
        check("async_rst_gameon", 32'(gameon), 0);
        check("async_rst_tick", 32'(score_tick), 0);
        check("async_rst_score", 32'(score), 0);
        #1 rst = 1'b0;
        step();
        check("post_rst_state", 32'(state), 0);

`ifdef GAME_HISCORE_EN
        check("hi_rst", 32'(hiscore), 0);
        pulse_start();
        for (int k = 1; k <= 29; k++) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("hi_game1_score", 32'(score), 7);
        check("hi_game1", 32'(hiscore), 7);
        pulse_start();
        check("hi_enter_play", 32'(hiscore), 7);
        for (int k = 1; k <= 13; k++) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("hi_game2_score", 32'(score), 3);
        check("hi_game2", 32'(hiscore), 7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_pace_controller.md
Name: game_pace_controller

Overview:
- Central game-state sequencer and tick scheduler for the dino game.
- Owns the IDLE/PLAY/OVER state machine and gates all tick generation by state.
- Produces single-cycle score and obstacle enable pulses, keeps the running score, and ramps obstacle speed with score.
- Sits between the button debouncer/collision detector and the score display and obstacle scroller.

Parameters:
- SCORE_DIV, 3000000: clk cycles per score tick (27 MHz -> 9 Hz).
- OBST_DIV_BASE, 270000: clk cycles per obstacle tick at level 0 (100 Hz).
- OBST_DIV_STEP, 20000: cycles removed from the obstacle period per level.
- OBST_DIV_MIN, 90000: floor on the obstacle period.
- LEVEL_PTS, 100: score points per level increment.
- MAX_LEVEL, 7: level saturation value.
- SCORE_MAX, 9999: score saturation value.

Ports:
- clk  in  1: 27 MHz system clock.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: single-cycle pulse from the debouncer, synchronous to clk.
- collision  in  1: level from the collision detector, synchronous to clk.
- state  out  2: 0 = IDLE, 1 = PLAY, 2 = OVER.
- gameon  out  1: high while state == PLAY.
- score_tick  out  1: one-cycle pulse per score increment.
- obstacle_tick  out  1: one-cycle pulse per obstacle scroll step.
- score  out  14: binary score, 0..SCORE_MAX.
- level  out  3: speed level, 0..MAX_LEVEL.

Behaviour:
- Reset (asynchronous, any time, including mid-PLAY):
  - state = IDLE; gameon, score_tick and obstacle_tick = 0; score = 0; level = 0.
  - Both divider counters = 0; point counter = 0; latched obstacle period = OBST_DIV_BASE.
- FSM:
  - IDLE -> PLAY on start.
  - PLAY -> OVER on collision.
  - OVER -> PLAY on start.
  - No other transitions. start in PLAY is ignored; collision in IDLE/OVER is ignored.
- Entering PLAY, on the transition cycle:
  - score, level and point counter cleared; both divider counters cleared.
  - Obstacle period latched to OBST_DIV_BASE.
- Score divider (PLAY only):
  - Counts 0..SCORE_DIV-1.
  - At SCORE_DIV-1 it wraps to 0 and asserts score_tick for exactly 1 cycle (registered output).
  - First score_tick occurs SCORE_DIV cycles after entering PLAY.
- Obstacle divider: same scheme against the latched period P.
  - P is recomputed only at each obstacle wrap, so no period is ever truncated.
  - P = max(OBST_DIV_BASE - level*OBST_DIV_STEP, OBST_DIV_MIN), using the level value current at the wrap.
- Outside PLAY:
  - Both counters are held at 0 and no ticks are issued.
  - score and level hold their last values so OVER can display the final score.
- Score arithmetic (applied on each score wrap):
  - score increments by 1 and saturates at SCORE_MAX.
  - Point counter counts 0..LEVEL_PTS-1. On wrap, level increments and saturates at MAX_LEVEL.
  - Once score is saturated, score and level are frozen and the point counter stops.
- Collision has priority: if collision and a divider wrap coincide, the transition to OVER happens, the tick is suppressed, and score is not incremented.
- start and collision in the same cycle in PLAY: collision wins.
- gameon is decoded combinationally from the state register.

Optional Feature:
- Macro: GAME_HISCORE_EN.
- When defined:
  - Adds output hiscore (14 bits), reset to 0.
  - On the PLAY -> OVER transition, hiscore <= max(hiscore, score).
  - hiscore is unaffected by entering PLAY.
- When undefined: the port and register are absent. All other behaviour is identical.

Decomposition:
- Package game_pkg:
  - State encoding constants ST_IDLE, ST_PLAY, ST_OVER.
  - Score width 14 and level width 3.
  - Default divider constants.
- Sub-module tick_divider, instantiated twice:
  - Ports: clk, rst, en, clr, period (runtime input), tick.
  - Owns the counter, wrap and pulse logic.
  - Period is sampled at wrap, which serves the obstacle path.
- The controller owns the FSM, score/level arithmetic and period computation.

Test Plan (bench params SCORE_DIV=4, OBST_DIV_BASE=10, OBST_DIV_STEP=2, OBST_DIV_MIN=4, LEVEL_PTS=3, MAX_LEVEL=7, SCORE_MAX=20):
- Reset then idle 50 cycles -> state=0, no ticks, score=0. start pulse -> state=1 next cycle; score_tick at cycles 4, 8, 12; obstacle_tick at cycle 10.
- Run in PLAY -> level becomes 1 at score 3 and 2 at score 6. Obstacle ticks spaced 10, then 8, then 6 cycles, with the change taking effect only at a wrap. Level 7 period = floor 4.
- Run to saturation -> score stays 20 and level stays 6, with score_tick still pulsing.
- Collision asserted on a score-wrap cycle with score=5 -> state=2, no score_tick, score stays 5. Later start -> state=1, score=0, first score_tick 4 cycles later.
- start and collision in the same PLAY cycle -> state=2. Collision in OVER -> no change.
- rst asserted mid-PLAY between clock edges -> outputs 0 immediately; after release, state=0.
- GAME_HISCORE_EN: game 1 ends at score 7 -> hiscore=7; game 2 ends at score 3 -> hiscore stays 7.
